irrigation_ctrl: RTL and testbench

IRRIGATION_CTRL -- requirements
Module: irrigation_ctrl

---
 rtl/irrigation_ctrl.sv | 152 +++++++++++++++
 tb/tb_irrigation_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/irrigation_ctrl.sv
// Tank/soil irrigation controller: level-classifying Moore FSM, run-length timer, display phase divider.
// Optional input debounce filter enabled by defining SENSOR_DEBOUNCE_EN.
module irrigation_ctrl #(
    parameter int MIN_RUN  = 16,
    parameter int DISP_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       l,
    input  logic       m,
    input  logic       h,
    input  logic       soil_dry,
    input  logic       err_clr,
    output logic       vs,
    output logic       bs,
    output logic       ve,
    output logic       alarm,
    output logic       m7,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        SPRINKLE = 3'd2,
        DRIP     = 3'd3,
        ERROR    = 3'd4
    } state_t;

    localparam int DW = $clog2(DISP_DIV);

    state_t       cur_st, nxt_st;
    logic [3:0]   raw;
    logic [3:0]   smp;
    logic         err_q;
    logic [7:0]   run_cnt;
    logic [DW-1:0] div_cnt;

    assign raw = {soil_dry, h, m, l};

`ifdef SENSOR_DEBOUNCE_EN
    logic [3:0]      sync1, sync2;
    logic [3:0][2:0] hist;

    // A filtered bit follows the synchronized input once it and the three prior samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
            smp   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 4; i++) begin
                hist[i] <= {hist[i][1:0], sync2[i]};
                if (hist[i] == {3{sync2[i]}})
                    smp[i] <= sync2[i];
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) smp <= '0;
        else        smp <= raw;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_clr;
    end

    logic soil_q, lv_empty, lv_low, lv_mid, lv_full, lv_valid, run_done;

    assign soil_q   = smp[3];
    assign lv_empty = (smp[2:0] == 3'b000);
    assign lv_low   = (smp[2:0] == 3'b001);
    assign lv_mid   = (smp[2:0] == 3'b011);
    assign lv_full  = (smp[2:0] == 3'b111);
    assign lv_valid = lv_empty | lv_low | lv_mid | lv_full;
    assign run_done = (run_cnt >= 8'(MIN_RUN - 1));

    always_comb begin
        nxt_st = cur_st;
        if (cur_st != ERROR && !lv_valid) begin
            nxt_st = ERROR;
        end else begin
            case (cur_st)
                IDLE: begin
                    if (lv_empty)                      nxt_st = FILL;
                    else if (soil_q && lv_low)         nxt_st = DRIP;
                    else if (soil_q)                   nxt_st = SPRINKLE;
                end
                FILL: begin
                    if (lv_full)                       nxt_st = IDLE;
                end
                SPRINKLE: begin
                    if (lv_empty)                      nxt_st = FILL;
                    else if (lv_low)                   nxt_st = DRIP;
                    else if (!soil_q && run_done)      nxt_st = IDLE;
                end
                DRIP: begin
                    if (lv_empty)                      nxt_st = FILL;
                    else if (soil_q && !lv_low)        nxt_st = SPRINKLE;
                    else if (!soil_q && run_done)      nxt_st = IDLE;
                end
                ERROR: begin
                    if (err_q && lv_valid)             nxt_st = IDLE;
                end
                default:                               nxt_st = IDLE;
            endcase
        end
    end

    // Valve/alarm flops load from the next state so they always match the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st  <= IDLE;
            run_cnt <= '0;
            ve      <= 1'b0;
            vs      <= 1'b0;
            bs      <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            cur_st <= nxt_st;
            if (nxt_st != cur_st)
                run_cnt <= '0;
            else if (run_cnt != 8'hFF)
                run_cnt <= run_cnt + 8'd1;
            ve    <= (nxt_st == FILL);
            vs    <= (nxt_st == SPRINKLE);
            bs    <= (nxt_st == DRIP);
            alarm <= (nxt_st == ERROR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            m7      <= 1'b0;
        end else if (div_cnt == DW'(DISP_DIV - 1)) begin
            div_cnt <= '0;
            m7      <= ~m7;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign state = cur_st;

endmodule

// File: tb/tb_irrigation_ctrl.sv
// Scoreboard bench for irrigation_ctrl: expectations queued at drive time, compared when due.
module tb_irrigation_ctrl;

`ifdef SENSOR_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 2;
`endif

    logic       clk, rst_n, l, m, h, soil_dry, err_clr;
    logic       vs, bs, ve, alarm, m7;
    logic [2:0] state;

    irrigation_ctrl #(.MIN_RUN(16), .DISP_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .l(l), .m(m), .h(h), .soil_dry(soil_dry),
        .err_clr(err_clr), .vs(vs), .bs(bs), .ve(ve), .alarm(alarm), .m7(m7), .state(state)
    );

    typedef struct {
        int         due;
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   m7_last = -1;
    int   m7_toggles = 0;
    logic m7_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {state, ve, vs, bs, alarm} for a state code.
    function automatic logic [6:0] pk(input logic [2:0] st);
        return {st, st == 3'd1, st == 3'd2, st == 3'd3, st == 3'd4};
    endfunction

    task automatic expect_at(input int d, input string tag, input logic [2:0] st);
        exp_t e;
        e.due = cyc + d;
        e.tag = tag;
        e.val = pk(st);
        sb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] hml, input logic s, input logic e);
        {h, m, l} = hml;
        soil_dry  = s;
        err_clr   = e;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check_eq(e.tag, {25'd0, state, ve, vs, bs, alarm}, {25'd0, e.val});
            end
            if (!rst_n) begin
                m7_last = -1;
                m7_prev = m7;
            end else if (m7 !== m7_prev) begin
                if (m7_last >= 0) check_eq("m7_period", cyc - m7_last, 4);
                m7_last = cyc;
                m7_prev = m7;
                m7_toggles++;
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        drive(3'b000, 1'b0, 1'b0);
        #2;
        check_eq("reset_outputs", {state, ve, vs, bs, alarm, m7}, 8'd0);
        wait_cyc(3);
        check_eq("reset_held_outputs", {state, ve, vs, bs, alarm, m7}, 8'd0);
        rst_n = 1'b1;

        // Empty tank right after reset fills, full tank returns to idle.
        expect_at(1, "fill_first_edge", 3'd1);
        wait_cyc(LAT + 1);
        drive(3'b111, 1'b0, 1'b0);
        expect_at(LAT, "full_to_idle", 3'd0);
        wait_cyc(LAT + 2);

        // Sprinkle at MID; soil goes wet after 5 cycles, minimum run still honoured.
        drive(3'b011, 1'b1, 1'b0);
        expect_at(LAT, "sprinkle_enter", 3'd2);
        wait_cyc(LAT + 5);
        drive(3'b011, 1'b0, 1'b0);
        expect_at(1, "sprinkle_hold_early", 3'd2);
        expect_at(10, "sprinkle_hold_cnt15", 3'd2);
        expect_at(11, "sprinkle_min_run_idle", 3'd0);
        wait_cyc(12);

        // Sprinkle -> drip -> sprinkle -> fill, irrigation inhibited while filling.
        drive(3'b011, 1'b1, 1'b0);
        expect_at(LAT, "sprinkle_again", 3'd2);
        wait_cyc(LAT + 2);
        drive(3'b001, 1'b1, 1'b0);
        expect_at(LAT, "low_to_drip", 3'd3);
        wait_cyc(LAT + 1);
        drive(3'b011, 1'b1, 1'b0);
        expect_at(LAT, "mid_to_sprinkle", 3'd2);
        wait_cyc(LAT + 1);
        drive(3'b000, 1'b1, 1'b0);
        expect_at(LAT, "empty_to_fill", 3'd1);
        wait_cyc(LAT + 1);
        drive(3'b011, 1'b1, 1'b0);
        expect_at(LAT, "fill_inhibit_a", 3'd1);
        expect_at(LAT + 3, "fill_inhibit_b", 3'd1);
        wait_cyc(LAT + 4);
        drive(3'b111, 1'b0, 1'b0);
        expect_at(LAT, "fill_done_idle", 3'd0);
        wait_cyc(LAT + 1);

        // Invalid level, err_clr ignored until the level is valid again.
        drive(3'b101, 1'b0, 1'b0);
        expect_at(LAT, "invalid_to_error", 3'd4);
        wait_cyc(LAT + 1);
        drive(3'b101, 1'b0, 1'b1);
        expect_at(2, "clr_invalid_stays_a", 3'd4);
        expect_at(LAT + 2, "clr_invalid_stays_b", 3'd4);
        wait_cyc(1);
        drive(3'b101, 1'b0, 1'b0);
        wait_cyc(LAT + 2);
        drive(3'b111, 1'b0, 1'b0);
        expect_at(LAT, "valid_no_clr_stays", 3'd4);
        wait_cyc(LAT + 1);
        drive(3'b111, 1'b0, 1'b1);
        expect_at(2, "clr_valid_idle", 3'd0);
        wait_cyc(1);
        drive(3'b111, 1'b0, 1'b0);
        wait_cyc(3);

        // Asynchronous reset in the middle of a fill.
        drive(3'b000, 1'b0, 1'b0);
        expect_at(LAT, "fill_before_rst", 3'd1);
        wait_cyc(LAT + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_mid_fill", {state, ve, vs, bs, alarm, m7}, 8'd0);
        drive(3'b111, 1'b0, 1'b0);
        wait_cyc(3);
        rst_n = 1'b1;
        expect_at(1, "fill_first_edge_2", 3'd1);
        expect_at(LAT + 1, "idle_after_rst", 3'd0);
        wait_cyc(LAT + 2);
        drive(3'b011, 1'b0, 1'b0);
        wait_cyc(LAT + 1);

`ifdef SENSOR_DEBOUNCE_EN
        // Short soil glitch is filtered, a steady one passes.
        drive(3'b011, 1'b1, 1'b0);
        expect_at(LAT, "glitch_idle_a", 3'd0);
        expect_at(LAT + 3, "glitch_idle_b", 3'd0);
        wait_cyc(3);
        drive(3'b011, 1'b0, 1'b0);
        wait_cyc(LAT + 4);
        drive(3'b011, 1'b1, 1'b0);
        expect_at(LAT, "steady_soil_sprinkle", 3'd2);
        wait_cyc(LAT + 1);
`endif

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) check_eq("scoreboard_drain", sb.size(), 0);
        check_eq("m7_toggled", (m7_toggles > 10) ? 32'd1 : 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
